// File: rtl/painel_pkg.sv
// Shared definitions for the panel shift-register sequencer:
// cell-mux select codes, sequencer states and speed-select width.
package painel_pkg;

  localparam int VEL_W = 2;

  localparam logic [1:0] SEL_CARGA     = 2'b00;
  localparam logic [1:0] SEL_POSTERIOR = 2'b01;
  localparam logic [1:0] SEL_ANTERIOR  = 2'b10;
  localparam logic [1:0] SEL_MANTER    = 2'b11;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    CARREGA = 2'b01,
    ROLANDO = 2'b10,
    PAUSADO = 2'b11
  } estado_t;

endpackage

// File: rtl/divisor_tick.sv
// Scroll-period prescaler: one-cycle tick every P = DIV_BASE << vel cycles,
// freezable via enable, restartable via synchronous clear; P latched per period.
module divisor_tick
  import painel_pkg::*;
#(
  parameter int DIV_BASE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [VEL_W-1:0] i_vel,
  output logic             o_tick
);

  localparam int PMAX = DIV_BASE << ((1 << VEL_W) - 1);
  localparam int CW   = $clog2(PMAX + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_periodo;
  logic [CW-1:0] w_periodo_novo;
  logic          w_fim;

  // End-of-period detect and period length for the next period
  always_comb begin
    w_periodo_novo = CW'(DIV_BASE) << i_vel;
    w_fim          = (r_cnt == (r_periodo - CW'(1)));
    o_tick         = i_en & ~i_clr & w_fim;
  end

  // Counter and latched period; a clear or a wrap both start a new period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= {CW{1'b0}};
      r_periodo <= CW'(DIV_BASE);
    end else if (i_clr || (i_en && w_fim)) begin
      r_cnt     <= {CW{1'b0}};
      r_periodo <= w_periodo_novo;
    end else if (i_en) begin
      r_cnt     <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/controle_rolagem.sv
// Universal shift-register sequencer: drives the shared (s1,s0) cell select to
// load, scroll, pause or hold, and tracks scroll position with a wrap pulse.
module controle_rolagem
  import painel_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DIV_BASE = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     carregar,
  input  logic                     iniciar,
  input  logic                     parar,
  input  logic                     pausa,
  input  logic                     direcao,
  input  logic [VEL_W-1:0]         velocidade,
  output logic                     s1,
  output logic                     s0,
  output logic                     ocupado,
  output logic [$clog2(WIDTH)-1:0] posicao,
  output logic                     fim_volta
);

  localparam int             PW      = $clog2(WIDTH);
  localparam logic [PW-1:0]  POS_MAX = PW'(WIDTH - 1);

  estado_t       r_estado;
  estado_t       w_estado_prox;
  logic [1:0]    r_sel;
  logic [1:0]    w_sel_prox;
  logic          r_direcao;
  logic          r_ocupado;
  logic          r_fim_volta;
  logic [PW-1:0] r_posicao;
  logic          w_en;
  logic          w_clr;
  logic          w_tick;

  divisor_tick #(
    .DIV_BASE (DIV_BASE)
  ) u_divisor (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_en),
    .i_clr  (w_clr),
    .i_vel  (velocidade),
    .o_tick (w_tick)
  );

  // Prescaler runs through the load cycle and scrolling, frozen while paused
  always_comb begin
    w_clr = carregar | parar | (r_estado == OCIOSO);
    case (r_estado)
      CARREGA: w_en = 1'b1;
      ROLANDO: w_en = ~pausa;
      default: w_en = 1'b0;
    endcase
  end

  // Next state and next select; priority carregar > parar > pausa > iniciar
  always_comb begin
    w_estado_prox = r_estado;
    w_sel_prox    = SEL_MANTER;
    case (r_estado)
      OCIOSO: begin
        if (carregar) begin
          w_estado_prox = CARREGA;
          w_sel_prox    = SEL_CARGA;
        end else if (iniciar && !parar && !pausa) begin
          w_estado_prox = ROLANDO;
        end else begin
          w_estado_prox = OCIOSO;
        end
      end
      CARREGA: begin
        if (carregar) begin
          w_estado_prox = CARREGA;
          w_sel_prox    = SEL_CARGA;
        end else if (parar) begin
          w_estado_prox = OCIOSO;
        end else begin
          w_estado_prox = ROLANDO;
        end
      end
      ROLANDO: begin
        if (carregar) begin
          w_estado_prox = CARREGA;
          w_sel_prox    = SEL_CARGA;
        end else if (parar) begin
          w_estado_prox = OCIOSO;
        end else if (pausa) begin
          w_estado_prox = PAUSADO;
        end else if (w_tick) begin
          w_estado_prox = ROLANDO;
          w_sel_prox    = r_direcao ? SEL_POSTERIOR : SEL_ANTERIOR;
        end else begin
          w_estado_prox = ROLANDO;
        end
      end
      PAUSADO: begin
        if (carregar) begin
          w_estado_prox = CARREGA;
          w_sel_prox    = SEL_CARGA;
        end else if (parar) begin
          w_estado_prox = OCIOSO;
        end else if (pausa) begin
          w_estado_prox = PAUSADO;
        end else begin
          w_estado_prox = ROLANDO;
        end
      end
      default: begin
        w_estado_prox = OCIOSO;
      end
    endcase
  end

  // State, select and busy registers; direction sampled at each period start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado  <= OCIOSO;
      r_sel     <= SEL_MANTER;
      r_ocupado <= 1'b0;
      r_direcao <= 1'b0;
    end else begin
      r_estado  <= w_estado_prox;
      r_sel     <= w_sel_prox;
      r_ocupado <= (w_estado_prox != OCIOSO);
      if (w_clr || w_tick) begin
        r_direcao <= direcao;
      end
    end
  end

  // Position follows the shift that just took place; wrap pulse on reaching 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_posicao   <= {PW{1'b0}};
      r_fim_volta <= 1'b0;
    end else if (carregar) begin
      r_posicao   <= {PW{1'b0}};
      r_fim_volta <= 1'b0;
    end else begin
      case (r_sel)
        SEL_ANTERIOR: begin
          r_posicao   <= (r_posicao == POS_MAX) ? {PW{1'b0}} : (r_posicao + PW'(1));
          r_fim_volta <= (r_posicao == POS_MAX);
        end
        SEL_POSTERIOR: begin
          r_posicao   <= (r_posicao == {PW{1'b0}}) ? POS_MAX : (r_posicao - PW'(1));
          r_fim_volta <= (r_posicao == PW'(1));
        end
        default: begin
          r_fim_volta <= 1'b0;
        end
      endcase
    end
  end

  assign s1        = r_sel[1];
  assign s0        = r_sel[0];
  assign ocupado   = r_ocupado;
  assign posicao   = r_posicao;
  assign fim_volta = r_fim_volta;

endmodule

// File: doc/controle_rolagem.md
# controle_rolagem

Sequencer for the panel's universal shift register: drives the shared select pair (s1, s0) of every 4:1 cell multiplexer so the register loads a message, scrolls it one bit per programmable period in either direction, pauses or holds. Sits between the panel user inputs (buttons/switches) and the register bank. It also tracks scroll position and flags each completed full rotation.

## Interface
Parameters:
- WIDTH, 16, number of register cells; position counter modulus
- DIV_BASE, 4, base scroll period in clock cycles (≥2)

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  reset, asynchronous and active-low
- carregar  input  1  load request, level sampled each edge
- iniciar  input  1  start scrolling from OCIOSO
- parar  input  1  stop scrolling, return to OCIOSO
- pausa  input  1  freeze scrolling while high
- direcao  input  1  0 = toward anterior (sel 10), 1 = toward posterior (sel 01)
- velocidade  input  2  period select: P = DIV_BASE << velocidade
- s1, s0  output  1 each  registered select to all cell muxes
- ocupado  output  1  high in CARREGA, ROLANDO, PAUSADO
- posicao  output  clog2(WIDTH)  shifts taken modulo WIDTH
- fim_volta  output  1  one-cycle pulse when posicao wraps

## Operation
- Select encoding (s1s0): 00 parallel load, 01 take posterior, 10 take anterior, 11 hold.
- States: OCIOSO, CARREGA, ROLANDO, PAUSADO.
- OCIOSO: sel 11. carregar → CARREGA. iniciar (no carregar) → ROLANDO.
- CARREGA: exactly one cycle, sel 00, posicao cleared to 0; then ROLANDO.
- ROLANDO: sel 11 except one cycle per period P with sel 01/10 per direcao. pausa → PAUSADO; parar → OCIOSO.
- PAUSADO: sel 11, prescaler frozen. pausa low → ROLANDO, prescaler resumes from the frozen count. parar → OCIOSO.
- Priority, highest first: rst_n, carregar (from any state, restarts load), parar, pausa, iniciar.
- direcao and velocidade are sampled at the start of each period. Mid-period changes take effect at the next period.
- posicao changes on each shift cycle: +1 for direcao 0, −1 for direcao 1, modulo WIDTH.
- fim_volta pulses in the cycle after the shift that moves posicao to 0 by increment from WIDTH−1 or by decrement from 1. A shift from 0 to WIDTH−1 does not pulse.
- parar keeps posicao. Only CARREGA or reset clears it.

## Timing
- Reset values: s1s0 = 11, ocupado = 0, posicao = 0, fim_volta = 0, prescaler = 0, state OCIOSO. Reset mid-scroll forces these immediately, asynchronously.
- All outputs are registered; sel never glitches.
- carregar high at edge n → sel 00 during cycle n+1 → sel 11 from n+2.
- The first shift cycle is P cycles after the load cycle. Subsequent shift cycles are spaced exactly P cycles apart while unpaused.
- iniciar from OCIOSO: the first shift cycle is P cycles after entry into ROLANDO.
- pausa and the shift cycle in the same edge: shift is suppressed, sel stays 11, posicao unchanged.
- posicao and fim_volta update on the edge that ends the shift cycle.

## Structure
- Package painel_pkg holds:
  - select constants SEL_CARGA = 00, SEL_POSTERIOR = 01, SEL_ANTERIOR = 10, SEL_MANTER = 11
  - the state enum
  - the velocidade width
- Sub-module divisor_tick: prescaler with enable (freeze) and synchronous clear. It outputs a one-cycle tick every P cycles and latches P at period start.
- The top level holds the FSM, the position counter and the output registers.

## Test plan
All scenarios use WIDTH = 8, DIV_BASE = 2.
- Reset → s1s0 = 11, ocupado = 0, posicao = 0. Assert rst_n low mid-ROLANDO → same values immediately.
- Load and left scroll, velocidade = 0, direcao = 0: pulse carregar → one cycle sel 00, then sel 10 every 2 cycles. After 8 shifts, posicao = 0 and fim_volta pulses exactly once.
- direcao = 1 after load, velocidade = 2 (P = 8): sel 01 every 8 cycles. posicao sequence is 7, 6, …; fim_volta pulses on the 1→0 shift only.
- pausa asserted on the shift-cycle edge for 5 cycles: no shift, sel 11 throughout. The shift occurs at the remaining prescaler count after release.
- carregar while ROLANDO and pausa both high: CARREGA wins, sel 00, posicao = 0.
- velocidade changed 0→3 mid-period: the current period completes at P = 2; the next spacing is 16.
